// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_pkg
//  Description : Shared FSM encoding and constants for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

   // Fetch FSM: normal fetch, waiting on memory, waiting on a killed access
   typedef enum logic [1:0] {
      S_FETCH     = 2'd0,
      S_MISS      = 2'd1,
      S_MISS_KILL = 2'd2
   } fetch_state_t;

   localparam logic [31:0] C_NOP      = 32'h0000_0000;
   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

   // Force an address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Decode-side controls, instruction-memory bus and IF/ID
//                outputs of the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        isJR;
   logic [31:0] jr_target;
   logic        Jump;
   logic [31:0] jump_target;
   logic [29:0] IM_addr;
   logic        IM_read;
   logic [31:0] IM_rdata;
   logic        IM_stall;
   logic [31:0] Instruction;
   logic [31:0] PC_plus4;
   logic        IF_valid;
   logic [31:0] fetch_count;

   // Fetch unit side
   modport master (
      input  stall, branch_taken, branch_target, isJR, jr_target, Jump,
             jump_target, IM_rdata, IM_stall,
      output IM_addr, IM_read, Instruction, PC_plus4, IF_valid, fetch_count
   );

   // Environment side (decode + instruction memory)
   modport slave (
      output stall, branch_taken, branch_target, isJR, jr_target, Jump,
             jump_target, IM_rdata, IM_stall,
      input  IM_addr, IM_read, Instruction, PC_plus4, IF_valid, fetch_count
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Hold has priority, then load;
//                otherwise a bubble (NOP, invalid) is inserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] NOP = C_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hold,
   input  logic        i_load,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   // Capture, hold, or flush the decode-stage instruction slot
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr    <= NOP;
         r_pc_plus4 <= 32'h0;
         r_valid    <= 1'b0;
      end else if (!i_hold) begin
         if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
         end else begin
            r_instr    <= NOP;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
         end
      end
   end

   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage with PC, redirect handling and a
//                small FSM that rides out instruction-memory wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = C_RESET_PC,
   parameter logic [31:0] NOP      = C_NOP
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_pend_pc;
   logic [31:0]  r_fetch_count;

   logic         w_redir;
   logic [31:0]  w_target;
   logic [31:0]  w_pc_plus4;
   logic         w_load;

   assign w_pc_plus4 = r_pc + 32'd4;

   // Redirect detection and target selection (branch > JR > jump)
   always_comb begin
      w_redir  = bus.branch_taken | bus.isJR | bus.Jump;
      w_target = word_align(bus.jump_target);
      if (bus.branch_taken)
         w_target = word_align(bus.branch_target);
      else if (bus.isJR)
         w_target = word_align(bus.jr_target);
   end

   // A word is delivered only when decode is not stalled, memory answered,
   // nothing redirects, and the access in flight was not killed
   always_comb begin
      w_load = !bus.stall && !bus.IM_stall && !w_redir &&
               (r_state != S_MISS_KILL);
   end

   // FSM, PC, pending-redirect target and delivered-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FETCH;
         r_pc          <= word_align(RESET_PC);
         r_pend_pc     <= 32'h0;
         r_fetch_count <= 32'h0;
      end else begin
         if (w_load)
            r_fetch_count <= r_fetch_count + 32'd1;
         case (r_state)
            S_FETCH, S_MISS: begin
               if (bus.stall) begin
                  // PC frozen; only follow the memory handshake so the same
                  // address is simply re-fetched once decode releases
                  r_state <= bus.IM_stall ? S_MISS : S_FETCH;
               end else if (w_redir) begin
                  if (bus.IM_stall) begin
                     r_pend_pc <= w_target;
                     r_state   <= S_MISS_KILL;
                  end else begin
                     r_pc    <= w_target;
                     r_state <= S_FETCH;
                  end
               end else if (bus.IM_stall) begin
                  r_state <= S_MISS;
               end else begin
                  r_pc    <= w_pc_plus4;
                  r_state <= S_FETCH;
               end
            end
            S_MISS_KILL: begin
               // Stay parked while decode stalls so the pending target survives
               if (!bus.stall) begin
                  if (bus.IM_stall) begin
                     if (w_redir)
                        r_pend_pc <= w_target;
                  end else begin
                     r_pc    <= w_redir ? w_target : r_pend_pc;
                     r_state <= S_FETCH;
                  end
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   if_id_reg #(
      .NOP (NOP)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .i_hold     (bus.stall),
      .i_load     (w_load),
      .i_instr    (bus.IM_rdata),
      .i_pc_plus4 (w_pc_plus4),
      .o_instr    (bus.Instruction),
      .o_pc_plus4 (bus.PC_plus4),
      .o_valid    (bus.IF_valid)
   );

   assign bus.IM_addr     = r_pc[31:2];
   assign bus.IM_read     = ~rst;
   assign bus.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   logic clk;
   logic rst;
   logic use_const;
   int   total;
   int   bad;

   instr_fetch_if u_if ();

   instr_fetch u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: constant word, or a word that encodes its own byte address
   assign u_if.IM_rdata = use_const ? 32'h2008_0005
                                    : (32'hC000_0000 | {u_if.IM_addr, 2'b00});

   // Advance one clock; sample point is 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [29:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid, input logic [31:0] cnt);
      chk({tag, ".addr"},  {2'b00, u_if.IM_addr},     {2'b00, addr});
      chk({tag, ".instr"}, u_if.Instruction,         instr);
      chk({tag, ".pc4"},   u_if.PC_plus4,            pc4);
      chk({tag, ".valid"}, {31'h0, u_if.IF_valid},   {31'h0, valid});
      chk({tag, ".cnt"},   u_if.fetch_count,         cnt);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      use_const = 1'b1;
      rst = 1'b1;
      u_if.stall = 1'b0;
      u_if.branch_taken = 1'b0;
      u_if.branch_target = 32'h0;
      u_if.isJR = 1'b0;
      u_if.jr_target = 32'h0;
      u_if.Jump = 1'b0;
      u_if.jump_target = 32'h0;
      u_if.IM_stall = 1'b0;

      // Reset state
      step();
      step();
      chk_out("reset", 30'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("reset.read", {31'h0, u_if.IM_read}, 32'h0);
      rst = 1'b0;
      #1;
      chk("run.read", {31'h0, u_if.IM_read}, 32'h1);

      // Sequential fetch of a constant word
      step();
      chk_out("seq1", 30'h1, 32'h2008_0005, 32'd4, 1'b1, 32'd1);
      step();
      chk_out("seq2", 30'h2, 32'h2008_0005, 32'd8, 1'b1, 32'd2);
      step();
      chk_out("seq3", 30'h3, 32'h2008_0005, 32'd12, 1'b1, 32'd3);
      step();
      chk_out("seq4", 30'h4, 32'h2008_0005, 32'd16, 1'b1, 32'd4);

      // Decode stall at PC=0x10 with a branch that must be ignored
      use_const = 1'b0;
      u_if.stall = 1'b1;
      u_if.branch_taken = 1'b1;
      u_if.branch_target = 32'h40;
      step();
      chk_out("stall1", 30'h4, 32'h2008_0005, 32'd16, 1'b1, 32'd4);
      step();
      chk_out("stall2", 30'h4, 32'h2008_0005, 32'd16, 1'b1, 32'd4);
      u_if.stall = 1'b0;
      u_if.branch_taken = 1'b0;
      step();
      chk_out("unstall", 30'h5, 32'hC000_0010, 32'h14, 1'b1, 32'd5);
      step();
      step();
      step();
      chk_out("pc20", 30'h8, 32'hC000_001C, 32'h20, 1'b1, 32'd8);

      // Taken branch at PC=0x20 beats a simultaneous JR
      u_if.branch_taken = 1'b1;
      u_if.branch_target = 32'h40;
      u_if.isJR = 1'b1;
      u_if.jr_target = 32'h80;
      step();
      chk_out("br.bubble", 30'h10, 32'h0, 32'h0, 1'b0, 32'd8);
      u_if.branch_taken = 1'b0;
      u_if.isJR = 1'b0;
      step();
      chk_out("br.tgt", 30'h11, 32'hC000_0040, 32'h44, 1'b1, 32'd9);

      // JR beats jump; misaligned target truncated
      u_if.isJR = 1'b1;
      u_if.jr_target = 32'h83;
      u_if.Jump = 1'b1;
      u_if.jump_target = 32'h100;
      step();
      chk_out("jr.bubble", 30'h20, 32'h0, 32'h0, 1'b0, 32'd9);
      u_if.isJR = 1'b0;
      u_if.Jump = 1'b0;
      step();
      chk_out("jr.tgt", 30'h21, 32'hC000_0080, 32'h84, 1'b1, 32'd10);

      // Memory miss for 3 cycles at PC=0x8
      u_if.Jump = 1'b1;
      u_if.jump_target = 32'h8;
      step();
      chk_out("j8", 30'h2, 32'h0, 32'h0, 1'b0, 32'd10);
      u_if.Jump = 1'b0;
      u_if.IM_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("miss", 30'h2, 32'h0, 32'h0, 1'b0, 32'd10);
      end
      u_if.IM_stall = 1'b0;
      step();
      chk_out("miss.done", 30'h3, 32'hC000_0008, 32'h0C, 1'b1, 32'd11);

      // Miss plus jump in the same cycle: returned word dropped
      u_if.Jump = 1'b1;
      u_if.jump_target = 32'h8;
      step();
      chk_out("j8b", 30'h2, 32'h0, 32'h0, 1'b0, 32'd11);
      u_if.jump_target = 32'h100;
      u_if.IM_stall = 1'b1;
      step();
      chk_out("kill1", 30'h2, 32'h0, 32'h0, 1'b0, 32'd11);
      u_if.Jump = 1'b0;
      step();
      chk_out("kill2", 30'h2, 32'h0, 32'h0, 1'b0, 32'd11);
      u_if.IM_stall = 1'b0;
      step();
      chk_out("kill.drop", 30'h40, 32'h0, 32'h0, 1'b0, 32'd11);
      step();
      chk_out("kill.tgt", 30'h41, 32'hC000_0100, 32'h104, 1'b1, 32'd12);

      // PC wrap at the top of the address space
      u_if.Jump = 1'b1;
      u_if.jump_target = 32'hFFFF_FFFC;
      step();
      chk_out("jtop", 30'h3FFF_FFFF, 32'h0, 32'h0, 1'b0, 32'd12);
      u_if.Jump = 1'b0;
      step();
      chk_out("wrap", 30'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd13);
      step();
      chk_out("post.wrap", 30'h1, 32'hC000_0000, 32'h4, 1'b1, 32'd14);

      // Reset in the middle of a miss
      u_if.IM_stall = 1'b1;
      step();
      chk_out("miss2", 30'h1, 32'h0, 32'h0, 1'b0, 32'd14);
      rst = 1'b1;
      step();
      chk_out("rst.miss", 30'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      chk("rst.read", {31'h0, u_if.IM_read}, 32'h0);
      rst = 1'b0;
      u_if.IM_stall = 1'b0;
      step();
      chk_out("after.rst", 30'h1, 32'hC000_0000, 32'h4, 1'b1, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in, 1, rising-edge clock; rst in, 1, synchronous active-high reset.
REQ-002 The block SHALL have these parameters (name, default, meaning): RESET_PC, 32'h0000_0000, first fetch address; NOP, 32'h0000_0000, bubble instruction word.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- stall  in  1  load-use hold requested by decode.
- branch_taken  in  1  branch resolved taken in decode.
- branch_target  in  32  branch destination.
- isJR  in  1  jump-register in decode.
- jr_target  in  32  rs value for JR.
- Jump  in  1  J/JAL in decode.
- jump_target  in  32  J/JAL destination.
- IM_addr  out  30  word address to instruction memory (PC[31:2]).
- IM_read  out  1  fetch request.
- IM_rdata  in  32  instruction word, valid in the cycle IM_stall=0.
- IM_stall  in  1  memory not ready; hold address.
- Instruction  out  32  IF/ID instruction to decode.
- PC_plus4  out  32  IF/ID PC+4 (JAL link, branch base).
- IF_valid  out  1  Instruction is real, not a bubble.
- fetch_count  out  32  delivered-instruction counter.

Function
REQ-004 The block SHALL hold PC in a 32-bit register; IM_addr SHALL equal PC[31:2]; PC[1:0] SHALL always be 0, with targets truncated to word alignment.
REQ-005 IM_read SHALL be 1 in every cycle except while rst=1.
REQ-006 redirect = branch_taken|isJR|Jump, with target priority branch_target > jr_target > jump_target.
REQ-007 stall SHALL have priority over redirect: with stall=1, PC, Instruction, PC_plus4 and IF_valid SHALL hold, and any redirect that cycle SHALL be ignored.
REQ-008 The FSM SHALL have three states: FETCH, MISS and MISS_KILL.
REQ-009 FETCH, IM_stall=0, stall=0, no redirect: PC<=PC+4; IF/ID<={IM_rdata, PC+4}; IF_valid<=1. Latency is one cycle from address to Instruction.
REQ-010 FETCH, stall=0, redirect: PC<=target; IF/ID<=NOP; IF_valid<=0. The fetched word SHALL be discarded even when IM_stall=0.
REQ-011 FETCH, IM_stall=1, stall=0, no redirect: go to MISS; PC holds; IF/ID<=NOP; IF_valid<=0.
REQ-012 FETCH, IM_stall=1, stall=0, redirect: latch target in pend_pc; go to MISS_KILL; PC holds; IF/ID<=NOP.
REQ-013 MISS: PC and IM_addr SHALL stay stable. On IM_stall=0 with no redirect, behave as REQ-009 and return to FETCH. A redirect while IM_stall=1 SHALL move to MISS_KILL per REQ-012. A redirect in the cycle IM_stall=0 SHALL behave as REQ-010 and return to FETCH.
REQ-014 MISS_KILL: PC holds; IF/ID<=NOP; later redirects SHALL overwrite pend_pc. On IM_stall=0: drop IM_rdata, PC<=pend_pc, return to FETCH.
REQ-015 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 fetch_count SHALL increment by 1 on each edge that loads IF_valid<=1 and SHALL wrap modulo 2^32.
REQ-017 IM_stall SHALL have no effect on IF/ID while stall=1; the FSM SHALL still track IM_stall (FETCH->MISS, MISS->FETCH with the word held until stall drops, by re-fetching the same PC).

Reset
REQ-018 On rst=1 at a clock edge: PC<=RESET_PC; Instruction<=NOP; PC_plus4<=0; IF_valid<=0; fetch_count<=0; pend_pc<=0; state<=FETCH. rst SHALL override all other inputs.
REQ-019 A reset during MISS or MISS_KILL SHALL abandon the access; the first post-reset address SHALL be RESET_PC.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the NOP constant and RESET_PC.
REQ-021 The IF/ID register (Instruction, PC_plus4, IF_valid with hold/flush controls) SHALL be the sub-module if_id_reg.
REQ-022 All outputs except IM_addr and IM_read SHALL be registered.

Verification
REQ-023 Reset, then 4 cycles with IM_rdata=32'h2008_0005, IM_stall=0 -> IM_addr 0,1,2,3; Instruction valid from cycle 2; PC_plus4 4,8,12; fetch_count=3.
REQ-024 stall=1 for 2 cycles at PC=0x10 -> PC, Instruction and fetch_count frozen; branch_taken=1 with branch_target=0x40 during stall is ignored.
REQ-025 branch_taken=1 with target 0x40 at PC=0x20 -> next IM_addr=0x10, IF_valid=0 for one cycle, then the instruction at 0x40 is delivered with PC_plus4=0x44.
REQ-026 IM_stall=1 for 3 cycles at PC=0x8 -> IM_addr stable at 0x2, 3 bubbles, then the word at 0x8 is delivered.
REQ-027 IM_stall=1 at PC=0x8 and Jump=1 with jump_target=0x100 in the same cycle -> MISS_KILL; the returned word is dropped; next IM_addr=0x40; fetch_count unchanged.
REQ-028 PC=32'hFFFF_FFFC, no stall -> next PC=0; rst=1 mid-MISS -> IM_addr=0, all outputs at reset values.
